// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave that bridges 32-bit master frames onto a
// simple register strobe interface running on the system clock.
//
// Frame (MSB first): [31:24] address, [23] cmd (0 write / 1 read),
// [22:16] ignored, [15:0] data.
//
// Ports
//   clk       system clock (the only clock used)
//   reset     synchronous active-high reset
//   spi_sclk  SPI clock from master (asynchronous, idle low)
//   spi_ssn   SPI slave select, active low (asynchronous)
//   spi_mosi  master-out data (asynchronous)
//   spi_miso  slave-out data, 0 outside the read data phase
//   wr_en     one-cycle write strobe
//   rd_req    one-cycle read request
//   addr      frame address, held until the next header completes
//   wdata     write data, valid with wr_en and held afterwards
//   rd_data   read data, sampled one clk after rd_req
module spi_slave_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_ssn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned HDR_LAST = 15;
  localparam int unsigned DAT_LAST = 31;
  localparam int unsigned CMD_BIT  = 15 - ADDR_W;

  typedef enum logic [2:0] {IDLE, HDR, WDAT, RDAT, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_ssn_s1, r_ssn_s2;
  logic              r_mosi_s1, r_mosi_s2;
  logic [1:0]        r_settle;
  logic              r_armed;
  logic              r_rd_ld;
  logic [DATA_W-2:0] r_shin;
  logic [DATA_W-2:0] r_shout;

  logic              w_sclk_rise;
  logic [DATA_W-1:0] w_word;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  // Received word including the bit arriving on the current edge.
  assign w_word      = {r_shin, r_mosi_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ssn_s1  <= 1'b1;
      r_ssn_s2  <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_settle  <= '0;
      r_armed   <= 1'b0;
      r_rd_ld   <= 1'b0;
      r_shin    <= '0;
      r_shout   <= '0;
      spi_miso  <= 1'b0;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ssn_s1  <= spi_ssn;
      r_ssn_s2  <= r_ssn_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      r_rd_ld   <= rd_req;

      // The ssn synchronizer holds its forced-high reset value for a couple
      // of cycles; only trust it once it has settled, and only arm a new
      // frame after a genuine SSN high so a reset mid-frame is not mistaken
      // for a fresh falling edge.
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd3) && r_ssn_s2) begin
        r_armed <= 1'b1;
      end

      if (r_ssn_s2) begin
        r_state  <= IDLE;
        spi_miso <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_armed) begin
              r_state <= HDR;
              r_cnt   <= '0;
              r_armed <= 1'b0;
            end
          end
          HDR: begin
            if (w_sclk_rise) begin
              r_shin <= w_word[DATA_W-2:0];
              r_cnt  <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(HDR_LAST)) begin
                addr <= w_word[15 -: ADDR_W];
                if (w_word[CMD_BIT]) begin
                  rd_req  <= 1'b1;
                  r_state <= RDAT;
                end else begin
                  r_state <= WDAT;
                end
              end
            end
          end
          WDAT: begin
            if (w_sclk_rise) begin
              r_shin <= w_word[DATA_W-2:0];
              r_cnt  <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(DAT_LAST)) begin
                wdata   <= w_word;
                wr_en   <= 1'b1;
                r_state <= DONE;
              end
            end
          end
          RDAT: begin
            // Load happens inside the mandatory header/data gap, so it
            // cannot collide with a data-phase edge.
            if (r_rd_ld) begin
              r_shout  <= rd_data[DATA_W-2:0];
              spi_miso <= rd_data[DATA_W-1];
            end else if (w_sclk_rise) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(DAT_LAST)) begin
                r_state  <= DONE;
                spi_miso <= 1'b0;
              end else begin
                spi_miso <= r_shout[DATA_W-2];
                r_shout  <= {r_shout[DATA_W-3:0], 1'b0};
              end
            end
          end
          DONE: begin
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed bench for spi_slave_if with a bit-banged master.
module tb_spi_slave_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_ssn, spi_mosi, spi_miso;
  logic        wr_en, rd_req;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rd_data;

  int total = 0;
  int bad   = 0;

  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          both_cnt = 0;
  logic [15:0] wr_log [64];
  logic [7:0]  rd_addr_seen = 8'h00;
  logic [15:0] rd_mem = 16'h0000;

  spi_slave_if #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_ssn(spi_ssn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .wr_en(wr_en), .rd_req(rd_req),
    .addr(addr), .wdata(wdata), .rd_data(rd_data)
  );

  always #10 clk = ~clk;

  // Registered read responder: data valid only in the cycle after rd_req.
  always @(posedge clk) rd_data <= rd_req ? rd_mem : 16'hDEAD;

  // Strobe monitor (counts high cycles, so a 2-cycle pulse counts twice).
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 64) wr_log[wr_cnt] = wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (rd_req) begin
      rd_cnt = rd_cnt + 1;
      rd_addr_seen = addr;
    end
    if (wr_en && rd_req) both_cnt = both_cnt + 1;
  end

  // Mode-0 master: MOSI set in low phase, MISO captured at rising edge.
  task automatic send_bits(input logic [31:0] f, input int n, output logic [15:0] rx);
    rx = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (i == 16) #200;
      spi_mosi = (i < 32) ? f[31-i] : 1'b0;
      #50;
      if (i >= 16 && i < 32) rx = {rx[14:0], spi_miso};
      spi_sclk = 1'b1;
      #50;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] a, input logic cmd, input logic [15:0] d,
                       input int n, output logic [15:0] rx);
    spi_ssn = 1'b0;
    #100;
    send_bits({a, cmd, 7'h00, d}, n, rx);
    #100;
    spi_ssn = 1'b1;
    spi_mosi = 1'b0;
    #300;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got %b exp 0", rd_req); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL reset_addr got %h exp 00", addr); end
    total++; if (wdata !== 16'h0000) begin bad++; $display("FAIL reset_wdata got %h exp 0000", wdata); end
    reset = 1'b0;
    #200;
  endtask

  task automatic test_write;
    int w0, r0;
    logic [15:0] rx;
    w0 = wr_cnt; r0 = rd_cnt;
    frame(8'h80, 1'b0, 16'h00F1, 32, rx);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL write_count got %0d exp 1", wr_cnt - w0); end
    total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL write_rd_req got %0d exp 0", rd_cnt - r0); end
    total++; if (addr !== 8'h80) begin bad++; $display("FAIL write_addr got %h exp 80", addr); end
    total++; if (wdata !== 16'h00F1) begin bad++; $display("FAIL write_wdata got %h exp 00f1", wdata); end
    total++; if (wr_log[w0] !== 16'h00F1) begin bad++; $display("FAIL write_strobe_data got %h exp 00f1", wr_log[w0]); end
  endtask

  task automatic test_back_to_back;
    int w0;
    logic [15:0] rx;
    logic [15:0] exp_d;
    w0 = wr_cnt;
    for (int k = 0; k < 4; k++) frame(8'h80, 1'b0, 16'h00F1 + 16'(k), 32, rx);
    total++; if (wr_cnt - w0 !== 4) begin bad++; $display("FAIL b2b_count got %0d exp 4", wr_cnt - w0); end
    for (int k = 0; k < 4; k++) begin
      exp_d = 16'h00F1 + 16'(k);
      total++; if (wr_log[w0+k] !== exp_d) begin bad++; $display("FAIL b2b_data%0d got %h exp %h", k, wr_log[w0+k], exp_d); end
    end
  endtask

  task automatic test_read;
    int w0, r0;
    logic [15:0] rx;
    w0 = wr_cnt; r0 = rd_cnt;
    rd_mem = 16'h2000;
    frame(8'h02, 1'b1, 16'h0000, 32, rx);
    total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL read_rd_req got %0d exp 1", rd_cnt - r0); end
    total++; if (rd_addr_seen !== 8'h02) begin bad++; $display("FAIL read_addr got %h exp 02", rd_addr_seen); end
    total++; if (rx !== 16'h2000) begin bad++; $display("FAIL read_miso got %h exp 2000", rx); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL read_wr_en got %0d exp 0", wr_cnt - w0); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL read_miso_idle got %b exp 0", spi_miso); end
    rd_mem = 16'hA5C3;
    frame(8'h55, 1'b1, 16'h0000, 32, rx);
    total++; if (rx !== 16'hA5C3) begin bad++; $display("FAIL read2_miso got %h exp a5c3", rx); end
    total++; if (rd_addr_seen !== 8'h55) begin bad++; $display("FAIL read2_addr got %h exp 55", rd_addr_seen); end
  endtask

  task automatic test_abort;
    int w0, r0;
    logic [15:0] rx;
    w0 = wr_cnt; r0 = rd_cnt;
    frame(8'h80, 1'b0, 16'h1234, 10, rx);
    total++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin bad++; $display("FAIL abort_strobe got %0d exp 0", (wr_cnt - w0) + (rd_cnt - r0)); end
    frame(8'h7F, 1'b0, 16'h000A, 32, rx);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL abort_next_count got %0d exp 1", wr_cnt - w0); end
    total++; if (addr !== 8'h7F) begin bad++; $display("FAIL abort_next_addr got %h exp 7f", addr); end
    total++; if (wdata !== 16'h000A) begin bad++; $display("FAIL abort_next_wdata got %h exp 000a", wdata); end
  endtask

  task automatic test_reset_mid;
    int w0;
    logic [15:0] rx;
    w0 = wr_cnt;
    spi_ssn = 1'b0;
    #100;
    send_bits({8'h33, 1'b0, 7'h00, 16'h1234}, 20, rx);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL midrst_addr got %h exp 00", addr); end
    total++; if (wdata !== 16'h0000) begin bad++; $display("FAIL midrst_wdata got %h exp 0000", wdata); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got %b exp 0", spi_miso); end
    #200;
    // SSN never went high: this whole frame must be ignored.
    send_bits({8'h44, 1'b0, 7'h00, 16'h5555}, 32, rx);
    #100;
    spi_ssn = 1'b1;
    #300;
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL midrst_wr_en got %0d exp 0", wr_cnt - w0); end
    frame(8'h11, 1'b0, 16'hBEEF, 32, rx);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL midrst_next_count got %0d exp 1", wr_cnt - w0); end
    total++; if (addr !== 8'h11) begin bad++; $display("FAIL midrst_next_addr got %h exp 11", addr); end
    total++; if (wdata !== 16'hBEEF) begin bad++; $display("FAIL midrst_next_wdata got %h exp beef", wdata); end
  endtask

  task automatic test_overrun;
    int w0;
    logic [15:0] rx;
    w0 = wr_cnt;
    frame(8'h00, 1'b0, 16'h0001, 36, rx);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL overrun_count got %0d exp 1", wr_cnt - w0); end
    total++; if (wdata !== 16'h0001) begin bad++; $display("FAIL overrun_wdata got %h exp 0001", wdata); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL overrun_addr got %h exp 00", addr); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got %0d exp 0", both_cnt); end
  endtask

  initial begin
    spi_sclk = 1'b0;
    spi_ssn  = 1'b1;
    spi_mosi = 1'b0;
    reset    = 1'b1;
    test_reset;
    test_write;
    test_back_to_back;
    test_read;
    test_abort;
    test_reset_mid;
    test_overrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, header address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); the block SHALL use this one clock only.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from master, asynchronous to clk, idle low.
REQ-006 SHALL have port spi_ssn  input  1  SPI slave select, active low, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  master-out data, asynchronous.
REQ-008 SHALL have port spi_miso  output  1  slave-out data.
REQ-009 SHALL have port wr_en  output  1  one-cycle write strobe.
REQ-010 SHALL have port rd_req  output  1  one-cycle read request.
REQ-011 SHALL have port addr  output  ADDR_W  frame address, held until the next header completes.
REQ-012 SHALL have port wdata  output  DATA_W  write data, valid with wr_en, held afterwards.
REQ-013 SHALL have port rd_data  input  DATA_W  read data, sampled exactly 1 clk after rd_req.

Function
REQ-014 SHALL pass spi_sclk, spi_ssn and spi_mosi through 2-FF synchronizers, then detect SCLK edges from the synchronized value.
REQ-015 SHALL operate correctly for SCLK high and low times >= 2 clk each; the nominal case is 10 MHz (50 ns high / 50 ns low).
REQ-016 Frame format SHALL be 32 bits, MSB first, mode 0: bits 31..24 = address, bit 23 = cmd (0 write, 1 read), bits 22..16 ignored, bits 15..0 = data.
REQ-017 SHALL sample MOSI on each detected SCLK rising edge while synchronized SSN = 0.
REQ-018 FSM states SHALL be IDLE, HDR, WDAT, RDAT and DONE.
REQ-019 IDLE -> HDR when synchronized SSN falls; 5-bit bit counter cleared.
REQ-020 HDR: after the 16th rising edge, SHALL latch addr; go to WDAT if cmd = 0; if cmd = 1, pulse rd_req the next clk and go to RDAT.
REQ-021 RDAT: one clk after rd_req, SHALL load rd_data into the output shift register and drive its MSB on spi_miso.
REQ-022 RDAT: SHALL shift to the next bit within 4 clk after each detected rising edge, so the bit is stable before the next master rising edge.
REQ-023 WDAT: after the 32nd rising edge, SHALL update wdata and pulse wr_en for exactly one clk.
REQ-024 After bit 32 of either frame type, SHALL enter DONE and ignore further SCLK edges until SSN goes high.
REQ-025 SSN high in any state SHALL return the FSM to IDLE; a frame aborted before bit 32 SHALL produce no wr_en and leave wdata unchanged.
REQ-026 spi_miso SHALL be 0 outside RDAT.
REQ-027 wr_en and rd_req SHALL never assert in the same cycle; at most one strobe per frame.
REQ-028 The master SHALL leave >= 10 clk (200 ns) between the header and the data phase; no other stall mechanism exists.

Reset
REQ-029 On reset, SHALL set FSM = IDLE, bit counter = 0, and synchronizers to the idle values (sclk 0, ssn 1).
REQ-030 On reset, SHALL set wr_en, rd_req, spi_miso = 0 and addr, wdata, shift registers = 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; the block SHALL wait for SSN high, then SSN low, before accepting a new frame.

Verification
REQ-032 Write 0x80 / 0x00F1 at 10 MHz SCLK -> one wr_en pulse, addr = 0x80, wdata = 0x00F1, rd_req never asserted.
REQ-033 Four back-to-back writes 0x00F1..0x00F4 to 0x80, each with SSN high for 300 ns between frames -> four wr_en pulses carrying the values in order.
REQ-034 Read 0x02 with rd_data = 0x2000 -> one rd_req pulse with addr = 0x02; master shifts in 0x2000; wr_en stays 0; spi_miso = 0 after SSN high.
REQ-035 SSN raised after 10 bits, then write 0x7F / 0x000A -> no strobe for the aborted frame; one wr_en with addr 0x7F, wdata 0x000A.
REQ-036 Reset pulsed during the data phase of a write -> no wr_en; all outputs 0; the next full frame completes correctly.
REQ-037 36 SCLK pulses in one frame (write 0x00 / 0x0001) -> exactly one wr_en, at bit 32, wdata = 0x0001.
